// File: rtl/axicb_pkg.sv
// axicb_pkg: shared constants, types and helpers for the crossbar arbiters
package axicb_pkg;

    localparam int PRIO_W   = 2;
    localparam int LAYER_NB = 5;

    typedef logic [PRIO_W-1:0] prio_t;

    // Layer index doubles as evaluation order: U first, P0 last
    typedef enum logic [2:0] {
        L_U  = 3'd0,
        L_P3 = 3'd1,
        L_P2 = 3'd2,
        L_P1 = 3'd3,
        L_P0 = 3'd4
    } layer_e;

    // Encodes a one-hot (or zero) vector of up to 32 bits into its index
    function automatic logic [4:0] onehot2idx(input logic [31:0] oh);
        onehot2idx = '0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) onehot2idx |= 5'(i);
    endfunction

endpackage

// File: rtl/axicb_rr_layer.sv
// axicb_rr_layer: one priority layer of the arbiter, round-robin pick with its own mask
module axicb_rr_layer
    import axicb_pkg::*;
#(
    parameter int REQ_NB = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic [REQ_NB-1:0] members,
    input  logic              upd,
    output logic [REQ_NB-1:0] grant,
    output logic              any
);

    logic [REQ_NB-1:0] mask;
    logic [REQ_NB-1:0] masked;
    logic [REQ_NB-1:0] pick;

    // Masked candidates first, wrap to all members; srst behaves as an all-ones mask
    always_comb begin
        masked = mask & members;
        pick   = (!srst && |masked) ? masked : members;
        grant  = pick & (~pick + REQ_NB'(1));
        any    = |members;
    end

    // Keep only indices above the winner; the top index wraps the mask back to all ones
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn)
            mask <= '1;
        else if (srst || (upd && grant[REQ_NB-1]))
            mask <= '1;
        else if (upd)
            mask <= ~(grant | (grant - REQ_NB'(1)));

endmodule

// File: rtl/axicb_rr_prio_arbiter.sv
// axicb_rr_prio_arbiter: priority-layered round-robin arbiter with starvation aging
module axicb_rr_prio_arbiter
    import axicb_pkg::*;
#(
    parameter int REQ_NB  = 4,
    parameter int AGE_MAX = 15
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      srst,
    input  logic                      en,
    input  logic [REQ_NB-1:0]         req,
    input  logic [2*REQ_NB-1:0]       prio,
    output logic [REQ_NB-1:0]         grant,
    output logic [$clog2(REQ_NB)-1:0] grant_id,
    output logic                      grant_urgent
);

    localparam int ID_W  = $clog2(REQ_NB);
    localparam int AGE_W = AGE_MAX > 0 ? $clog2(AGE_MAX + 1) : 1;

    logic [AGE_W-1:0]    age     [REQ_NB];
    logic [REQ_NB-1:0]   urgent;
    logic [REQ_NB-1:0]   members [LAYER_NB];
    logic [REQ_NB-1:0]   lgrant  [LAYER_NB];
    logic [LAYER_NB-1:0] lany;
    logic [LAYER_NB-1:0] lupd;
    layer_e              win;
    logic                accept;

    // Aged requesters form the urgent layer; srst makes all ages read as zero
    always_comb begin
        urgent = '0;
        for (int i = 0; i < REQ_NB; i++)
            urgent[i] = (AGE_MAX != 0) && !srst && req[i] && age[i] == AGE_W'(AGE_MAX);
    end

    // Non-urgent requesters are sorted into P3..P0 by their current priority
    always_comb begin
        members[L_U] = urgent;
        for (int l = 1; l < LAYER_NB; l++)
            for (int i = 0; i < REQ_NB; i++)
                members[l][i] = req[i] && !urgent[i] && prio[PRIO_W*i +: PRIO_W] == prio_t'(LAYER_NB - 1 - l);
    end

    for (genvar l = 0; l < LAYER_NB; l++) begin : g_layer
        axicb_rr_layer #(.REQ_NB(REQ_NB)) u_layer (
            .aclk    (aclk),
            .aresetn (aresetn),
            .srst    (srst),
            .members (members[l]),
            .upd     (lupd[l]),
            .grant   (lgrant[l]),
            .any     (lany[l])
        );
        assign lupd[l] = accept && win == layer_e'(l);
    end

    // Highest non-empty layer wins; an empty P0 yields a zero grant
    always_comb begin
        win = L_P0;
        for (int l = LAYER_NB - 1; l >= 0; l--)
            if (lany[l]) win = layer_e'(l);
    end

    // Output encode and round acceptance
    always_comb begin
        grant        = lgrant[win];
        grant_id     = ID_W'(onehot2idx(32'(grant)));
        grant_urgent = lany[L_U];
        accept       = en && |grant && !srst;
    end

    // Ages: cleared when idle or granted, saturating count while losing accepted rounds
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn)
            for (int i = 0; i < REQ_NB; i++) age[i] <= '0;
        else
            for (int i = 0; i < REQ_NB; i++)
                age[i] <= (srst || !req[i] || (accept && grant[i])) ? '0 :
                          (accept && age[i] != AGE_W'(AGE_MAX)) ? age[i] + AGE_W'(1) : age[i];

endmodule

// File: tb/tb_axicb_rr_prio_arbiter.sv
// tb_axicb_rr_prio_arbiter: directed and randomized checks of four arbiter builds against a reference model
module tb_axicb_rr_prio_arbiter;

    localparam int NS  [4] = '{4, 8, 3, 32};
    localparam int AMS [4] = '{0, 3, 2, 15};

    logic        clk = 0, aresetn = 0, srst = 0, en = 0;
    logic [31:0] req_all = '0;
    logic [63:0] prio_all = '0;

    logic [3:0]  g4;  logic [1:0] id4;  logic u4;
    logic [7:0]  g8;  logic [2:0] id8;  logic u8;
    logic [2:0]  g3;  logic [1:0] id3;  logic u3;
    logic [31:0] g32; logic [4:0] id32; logic u32;

    logic [31:0] dg  [4];
    logic [4:0]  did [4];
    logic        du  [4];

    int checks = 0, passes = 0;

    int age_m  [4][32];
    int last_m [4][5];

    always #5 clk = ~clk;

    axicb_rr_prio_arbiter #(.REQ_NB(4), .AGE_MAX(0)) dut4 (
        .aclk(clk), .aresetn(aresetn), .srst(srst), .en(en), .req(req_all[3:0]), .prio(prio_all[7:0]),
        .grant(g4), .grant_id(id4), .grant_urgent(u4));
    axicb_rr_prio_arbiter #(.REQ_NB(8), .AGE_MAX(3)) dut8 (
        .aclk(clk), .aresetn(aresetn), .srst(srst), .en(en), .req(req_all[7:0]), .prio(prio_all[15:0]),
        .grant(g8), .grant_id(id8), .grant_urgent(u8));
    axicb_rr_prio_arbiter #(.REQ_NB(3), .AGE_MAX(2)) dut3 (
        .aclk(clk), .aresetn(aresetn), .srst(srst), .en(en), .req(req_all[2:0]), .prio(prio_all[5:0]),
        .grant(g3), .grant_id(id3), .grant_urgent(u3));
    axicb_rr_prio_arbiter #(.REQ_NB(32), .AGE_MAX(15)) dut32 (
        .aclk(clk), .aresetn(aresetn), .srst(srst), .en(en), .req(req_all), .prio(prio_all),
        .grant(g32), .grant_id(id32), .grant_urgent(u32));

    assign dg[0] = 32'(g4);  assign did[0] = 5'(id4);  assign du[0] = u4;
    assign dg[1] = 32'(g8);  assign did[1] = 5'(id8);  assign du[1] = u8;
    assign dg[2] = 32'(g3);  assign did[2] = 5'(id3);  assign du[2] = u3;
    assign dg[3] = g32;      assign did[3] = id32;     assign du[3] = u32;

    // Reference: each layer remembers its last winner; pick the next member after it, else the first
    function automatic void model_arb(input int k, input logic [31:0] r, input logic [63:0] p, input logic s,
                                      output logic [31:0] g, output int id, output logic urg, output int lay);
        int n, am, first, after, a, last;
        logic u, m;
        n = NS[k]; am = AMS[k];
        g = '0; id = 0; urg = 0; lay = -1;
        for (int l = 0; l < 5 && lay < 0; l++) begin
            first = -1; after = -1;
            last = s ? -1 : last_m[k][l];
            for (int i = 0; i < n; i++) begin
                a = s ? 0 : age_m[k][i];
                u = am != 0 && r[i] && a == am;
                m = (l == 0) ? u : (r[i] && !u && int'(p[2*i +: 2]) == 4 - l);
                if (m && first < 0) first = i;
                if (m && after < 0 && i > last) after = i;
            end
            if (first >= 0) begin
                lay = l;
                id  = after >= 0 ? after : first;
                g   = 32'd1 << id;
                urg = l == 0;
            end
        end
    endfunction

    logic [31:0] mg;
    int          mid, mlay;
    logic        murg;

    // Reference state update, one step per clock
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < 32; i++) age_m[k][i] <= 0;
                for (int l = 0; l < 5; l++) last_m[k][l] <= -1;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                model_arb(k, req_all, prio_all, srst, mg, mid, murg, mlay);
                for (int i = 0; i < NS[k]; i++)
                    if (srst || !req_all[i]) age_m[k][i] <= 0;
                    else if (en && mg != 0) age_m[k][i] <= mg[i] ? 0 : (age_m[k][i] < AMS[k] ? age_m[k][i] + 1 : age_m[k][i]);
                for (int l = 0; l < 5; l++)
                    if (srst) last_m[k][l] <= -1;
                    else if (en && mg != 0 && l == mlay) last_m[k][l] <= (mid == NS[k] - 1) ? -1 : mid;
            end
        end
    end

    task automatic do_srst;
        @(negedge clk); srst = 1; en = 0;
        @(negedge clk); srst = 0;
    endtask

    task automatic test_reset;
        @(negedge clk); req_all = '0; #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({dg[k], did[k], du[k]} !== 38'd0)
                $display("FAIL reset_idle k%0d grant=%h id=%0d urg=%b need 0/0/0", k, dg[k], did[k], du[k]);
            else passes++;
        end
        req_all = 32'hF; #1;
        checks++;
        if (g4 !== 4'b0001) $display("FAIL reset_req grant=%b need 0001", g4); else passes++;
        @(negedge clk); aresetn = 1;
    endtask

    task automatic test_rotation;
        logic [3:0] e [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_srst();
        prio_all = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); req_all = 32'hF; en = 1; #1;
            checks++;
            if (g4 !== e[c] || id4 !== 2'(c % 4)) $display("FAIL rotation c%0d grant=%b id=%0d need %b", c, g4, id4, e[c]);
            else passes++;
        end
    endtask

    task automatic test_mask_wrap;
        logic [3:0] r [6] = '{4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b0011, 4'b0011};
        logic [3:0] e [6] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0001};
        do_srst();
        prio_all = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); req_all = 32'(r[c]); en = 1; #1;
            checks++;
            if (g4 !== e[c]) $display("FAIL mask_wrap c%0d grant=%b need %b", c, g4, e[c]);
            else passes++;
        end
    endtask

    task automatic test_prio_layers;
        logic [3:0] r [5] = '{4'b1111, 4'b1011, 4'b1011, 4'b1111, 4'b1011};
        logic [3:0] e [5] = '{4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_srst();
        prio_all = 64'h30;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); req_all = 32'(r[c]); en = 1; #1;
            checks++;
            if (g4 !== e[c]) $display("FAIL prio_layers c%0d grant=%b need %b", c, g4, e[c]);
            else passes++;
        end
    endtask

    task automatic test_aging;
        logic [7:0] e [5] = '{8'h01, 8'h01, 8'h01, 8'h80, 8'h01};
        logic       eu [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_srst();
        prio_all = 64'h3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); req_all = 32'h81; en = 1; #1;
            checks++;
            if (g8 !== e[c] || u8 !== eu[c]) $display("FAIL aging c%0d grant=%h urg=%b need %h/%b", c, g8, u8, e[c], eu[c]);
            else passes++;
        end
    endtask

    task automatic test_hold_and_resets;
        logic [3:0] e [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0001};
        do_srst();
        prio_all = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); req_all = 32'hF; en = 0; #1;
            checks++;
            if (g4 !== 4'b0001) $display("FAIL hold c%0d grant=%b need 0001", c, g4); else passes++;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); en = 1; srst = (c == 2); #1;
            checks++;
            if (g4 !== e[c]) $display("FAIL srst_seq c%0d grant=%b need %b", c, g4, e[c]); else passes++;
        end
        @(negedge clk); srst = 0; #1;
        checks++;
        if (g4 !== 4'b0010) $display("FAIL after_srst grant=%b need 0010", g4); else passes++;
        @(negedge clk); aresetn = 0; #1;
        checks++;
        if (g4 !== 4'b0001) $display("FAIL async_reset grant=%b need 0001", g4); else passes++;
        @(negedge clk); aresetn = 1; #1;
        checks++;
        if (g4 !== 4'b0001) $display("FAIL after_areset grant=%b need 0001", g4); else passes++;
    endtask

    task automatic test_full_rotation;
        do_srst();
        prio_all = '0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk); req_all = '1; en = 1; #1;
            checks++;
            if (g32 !== 32'd1 << (c % 32) || int'(id32) != c % 32)
                $display("FAIL rot32 c%0d grant=%h id=%0d need id %0d", c, g32, id32, c % 32);
            else passes++;
            checks++;
            if (g3 !== 3'(3'd1 << (c % 3)) || int'(id3) != c % 3)
                $display("FAIL rot3 c%0d grant=%b id=%0d need id %0d", c, g3, id3, c % 3);
            else passes++;
        end
    endtask

    task automatic test_random;
        logic [31:0] eg;
        int          eid, el;
        logic        eu;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            req_all  = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & $urandom);
            prio_all = {$urandom, $urandom};
            en       = $urandom_range(0, 3) != 0;
            srst     = $urandom_range(0, 199) == 0;
            #1;
            for (int k = 0; k < 4; k++) begin
                model_arb(k, req_all, prio_all, srst, eg, eid, eu, el);
                checks++;
                if (dg[k] !== eg || did[k] !== 5'(eid) || du[k] !== eu)
                    $display("FAIL random c%0d k%0d grant=%h id=%0d urg=%b need %h/%0d/%b", c, k, dg[k], did[k], du[k], eg, eid, eu);
                else passes++;
            end
        end
        @(negedge clk); srst = 0; en = 0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_mask_wrap();
        test_prio_layers();
        test_aging();
        test_hold_and_resets();
        test_full_rotation();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
